raw2yuv_stream: RTL and testbench

Streaming, parametrised successor to the combinational Bayer-to-YUV422 converter in the camera image data converter.
- Each accepted beat is one 2x2 Bayer quad, two pixels from each of two sensor rows; each beat emits one packed YUV422 pixel pair.
- Adds valid/ready handshaking with full backpressure, a 3-stage pipeline, selectable raw bit depth, a run-time Bayer phase, and line/frame position flags.
- Sits between the dual-line raw buffer and the AXI-Stream/VDMA packer.

---
 rtl/raw2yuv_stream.sv | 183 ++++++++++++++++++
 tb/tb_raw2yuv_stream.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/raw2yuv_stream.sv
// raw2yuv_stream: streaming 2x2 Bayer quad to packed YUV422 pixel pair.
// Three stages: demosaic, BT.601 multiply, round/clamp/pack, full backpressure.
// Ports: CLK, RESET (sync, active-high), BAYER_MODE (latched on SOF quads),
//   IN_VALID/IN_READY/IN_SOF/DATA_IN1 {P01,P00}/DATA_IN2 {P11,P10},
//   OUT_VALID/OUT_READY/YUV_DATA_OUT {Y0,U,Y1,V}/OUT_SOF/OUT_EOL/OUT_EOF.
// Option macro RAW2YUV_CHROMA_AVG_EN: U/V averaged over the pair,
//   otherwise U from pixel 0 and V from pixel 1.
module raw2yuv_stream #(
  parameter int PIX_WIDTH  = 8,
  parameter int LINE_PAIRS = 320,
  parameter int LINES      = 240
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [1:0]             BAYER_MODE,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic                   IN_SOF,
  input  logic [2*PIX_WIDTH-1:0] DATA_IN1,
  input  logic [2*PIX_WIDTH-1:0] DATA_IN2,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [31:0]            YUV_DATA_OUT,
  output logic                   OUT_SOF,
  output logic                   OUT_EOL,
  output logic                   OUT_EOF
);

  localparam int PW = $clog2(LINE_PAIRS);
  localparam int LW = (LINES > 1) ? $clog2(LINES) : 1;
  localparam logic [PW-1:0] LAST_PAIR = PW'(LINE_PAIRS - 1);
  localparam logic [LW-1:0] LAST_LINE = LW'(LINES - 1);

  function automatic logic signed [17:0] mac(
    input logic [7:0]         r,
    input logic [7:0]         g,
    input logic [7:0]         b,
    input logic signed [17:0] kr,
    input logic signed [17:0] kg,
    input logic signed [17:0] kb
  );
    return kr * $signed({10'd0, r})
         + kg * $signed({10'd0, g})
         + kb * $signed({10'd0, b})
         + 18'sd128;
  endfunction

  function automatic logic [7:0] fin(
    input logic signed [17:0] acc,
    input logic signed [17:0] off
  );
    logic signed [17:0] t;
    t = (acc >>> 8) + off;
    if (t < 18'sd0) return 8'd0;
    if (t > 18'sd255) return 8'd255;
    return t[7:0];
  endfunction

  logic en;
  logic xfer;
  assign en       = !OUT_VALID || OUT_READY;
  assign IN_READY = en;
  assign xfer     = IN_VALID && en;

  logic [7:0] p00, p01, p10, p11;
  assign p00 = DATA_IN1[PIX_WIDTH-1 -: 8];
  assign p01 = DATA_IN1[2*PIX_WIDTH-1 -: 8];
  assign p10 = DATA_IN2[PIX_WIDTH-1 -: 8];
  assign p11 = DATA_IN2[2*PIX_WIDTH-1 -: 8];

  // The SOF quad already uses the mode it loads.
  logic [1:0] mode_q;
  logic [1:0] mode;
  assign mode = (xfer && IN_SOF) ? BAYER_MODE : mode_q;

  logic [7:0] r_d, gt_d, gb_d, b_d;
  always_comb begin
    r_d  = p00;
    gt_d = p01;
    gb_d = p10;
    b_d  = p11;
    unique case (1'b1)
      mode == 2'd1: begin
        r_d = p01; gt_d = p00; gb_d = p11; b_d = p10;
      end
      mode == 2'd2: begin
        r_d = p10; gt_d = p00; gb_d = p11; b_d = p01;
      end
      mode == 2'd3: begin
        r_d = p11; gt_d = p01; gb_d = p10; b_d = p00;
      end
      default: ;
    endcase
  end

  logic       s1_valid, s1_sof;
  logic [7:0] s1_r, s1_gt, s1_gb, s1_b;
  logic       s2_valid, s2_sof;
  logic signed [17:0] s2_y0, s2_u0, s2_y1, s2_v1;

  always_ff @(posedge CLK) begin
    if (en) begin
      s1_sof <= IN_SOF;
      s1_r   <= r_d;
      s1_gt  <= gt_d;
      s1_gb  <= gb_d;
      s1_b   <= b_d;
      s2_sof <= s1_sof;
      s2_y0  <= mac(s1_r, s1_gt, s1_b, 18'sd66, 18'sd129, 18'sd25);
      s2_u0  <= mac(s1_r, s1_gt, s1_b, -18'sd38, -18'sd74, 18'sd112);
      s2_y1  <= mac(s1_r, s1_gb, s1_b, 18'sd66, 18'sd129, 18'sd25);
      s2_v1  <= mac(s1_r, s1_gb, s1_b, 18'sd112, -18'sd94, -18'sd18);
    end
  end

  logic [7:0] y0_f, y1_f, u_o, v_o;
  assign y0_f = fin(s2_y0, 18'sd16);
  assign y1_f = fin(s2_y1, 18'sd16);

`ifdef RAW2YUV_CHROMA_AVG_EN
  logic signed [17:0] s2_u1, s2_v0;
  always_ff @(posedge CLK) begin
    if (en) begin
      s2_u1 <= mac(s1_r, s1_gb, s1_b, -18'sd38, -18'sd74, 18'sd112);
      s2_v0 <= mac(s1_r, s1_gt, s1_b, 18'sd112, -18'sd94, -18'sd18);
    end
  end
  logic [8:0] u_sum, v_sum;
  assign u_sum = {1'b0, fin(s2_u0, 18'sd128)}
               + {1'b0, fin(s2_u1, 18'sd128)} + 9'd1;
  assign v_sum = {1'b0, fin(s2_v0, 18'sd128)}
               + {1'b0, fin(s2_v1, 18'sd128)} + 9'd1;
  assign u_o = u_sum[8:1];
  assign v_o = v_sum[8:1];
`else
  assign u_o = fin(s2_u0, 18'sd128);
  assign v_o = fin(s2_v1, 18'sd128);
`endif

  // Positions are assigned as pairs enter the output register; every
  // loaded pair leaves in order, so this matches counting transfers.
  logic [PW-1:0] pair_cnt, pos_pair;
  logic [LW-1:0] line_cnt, pos_line;
  logic          eol, eof;
  assign pos_pair = s2_sof ? '0 : pair_cnt;
  assign pos_line = s2_sof ? '0 : line_cnt;
  assign eol      = (pos_pair == LAST_PAIR);
  assign eof      = eol && (pos_line == LAST_LINE);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      mode_q       <= 2'd0;
      s1_valid     <= 1'b0;
      s2_valid     <= 1'b0;
      OUT_VALID    <= 1'b0;
      OUT_SOF      <= 1'b0;
      OUT_EOL      <= 1'b0;
      OUT_EOF      <= 1'b0;
      YUV_DATA_OUT <= '0;
      pair_cnt     <= '0;
      line_cnt     <= '0;
    end else begin
      if (xfer && IN_SOF) mode_q <= BAYER_MODE;
      if (en) begin
        s1_valid  <= xfer;
        s2_valid  <= s1_valid;
        OUT_VALID <= s2_valid;
        OUT_SOF   <= s2_valid && s2_sof;
        OUT_EOL   <= s2_valid && eol;
        OUT_EOF   <= s2_valid && eof;
        if (s2_valid) begin
          YUV_DATA_OUT <= {y0_f, u_o, y1_f, v_o};
          pair_cnt     <= eol ? '0 : pos_pair + 1'b1;
          if (eol)
            line_cnt <= (pos_line == LAST_LINE) ? '0 : pos_line + 1'b1;
          else
            line_cnt <= pos_line;
        end
      end
    end
  end

endmodule

// File: tb/tb_raw2yuv_stream.sv
// tb_raw2yuv_stream: randomized and directed bench for raw2yuv_stream.
// Two instances (8-bit and 10-bit raw) share handshake and control.
module tb_raw2yuv_stream;

  localparam int LP = 4;
  localparam int NL = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic        out_ready = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic [15:0] a1 = '0, a2 = '0;
  logic [19:0] b1 = '0, b2 = '0;

  logic        rdy8, ov8, sof8, eol8, eof8;
  logic [31:0] yuv8;
  logic        rdy10, ov10, sof10, eol10, eof10;
  logic [31:0] yuv10;

  raw2yuv_stream #(.PIX_WIDTH(8), .LINE_PAIRS(LP), .LINES(NL)) u8 (
    .CLK(clk), .RESET(rst), .BAYER_MODE(mode),
    .IN_VALID(in_valid), .IN_READY(rdy8), .IN_SOF(in_sof),
    .DATA_IN1(a1), .DATA_IN2(a2),
    .OUT_VALID(ov8), .OUT_READY(out_ready), .YUV_DATA_OUT(yuv8),
    .OUT_SOF(sof8), .OUT_EOL(eol8), .OUT_EOF(eof8)
  );

  raw2yuv_stream #(.PIX_WIDTH(10), .LINE_PAIRS(LP), .LINES(NL)) u10 (
    .CLK(clk), .RESET(rst), .BAYER_MODE(mode),
    .IN_VALID(in_valid), .IN_READY(rdy10), .IN_SOF(in_sof),
    .DATA_IN1(b1), .DATA_IN2(b2),
    .OUT_VALID(ov10), .OUT_READY(out_ready), .YUV_DATA_OUT(yuv10),
    .OUT_SOF(sof10), .OUT_EOL(eol10), .OUT_EOF(eof10)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic int fl256(input int x);
    if (x >= 0) return x / 256;
    return -((-x + 255) / 256);
  endfunction

  function automatic int clip(input int x);
    return (x < 0) ? 0 : ((x > 255) ? 255 : x);
  endfunction

  function automatic logic [31:0] yuv(input logic [7:0] q00, q01, q10, q11,
                                      input int m);
    int px[4];
    int rs[4] = '{0, 1, 2, 3};
    int bs[4] = '{3, 2, 1, 0};
    int ts[4] = '{1, 0, 0, 1};
    int gs[4] = '{2, 3, 3, 2};
    int r, b, g0, g1, y0, y1, u0, u1, v0, v1, uo, vo;
    px[0] = q00; px[1] = q01; px[2] = q10; px[3] = q11;
    r  = px[rs[m]];
    b  = px[bs[m]];
    g0 = px[ts[m]];
    g1 = px[gs[m]];
    y0 = clip(fl256(66 * r + 129 * g0 + 25 * b + 128) + 16);
    y1 = clip(fl256(66 * r + 129 * g1 + 25 * b + 128) + 16);
    u0 = clip(fl256(-38 * r - 74 * g0 + 112 * b + 128) + 128);
    u1 = clip(fl256(-38 * r - 74 * g1 + 112 * b + 128) + 128);
    v0 = clip(fl256(112 * r - 94 * g0 - 18 * b + 128) + 128);
    v1 = clip(fl256(112 * r - 94 * g1 - 18 * b + 128) + 128);
`ifdef RAW2YUV_CHROMA_AVG_EN
    uo = (u0 + u1 + 1) / 2;
    vo = (v0 + v1 + 1) / 2;
`else
    uo = u0;
    vo = v1;
`endif
    return {8'(y0), 8'(uo), 8'(y1), 8'(vo)};
  endfunction

  typedef struct {
    logic [31:0] w8;
    logic [31:0] w10;
    logic [2:0]  fl;
    int          t;
  } exp_t;

  exp_t        q[$];
  logic [2:0]  hist[$];
  int          cyc = 0;
  int          m_mode = 0, m_pair = 0, m_line = 0;
  bit          stall_p = 0;
  bit          lat_on = 1;
  bit          in_took = 0;
  int          rdy_mode = 0;
  logic [34:0] held8, held10;
  logic [31:0] last8 = '0, last10 = '0;

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin : mon
    exp_t e;
    cyc++;
    in_took = 0;
    if (rst) begin
      q.delete();
      stall_p = 0;
      m_mode = 0;
      m_pair = 0;
      m_line = 0;
    end else begin
      chk("in_ready8", rdy8, !(ov8 && !out_ready));
      chk("in_ready10", rdy10, !(ov8 && !out_ready));
      if (stall_p) begin
        chk("hold8", {ov8, yuv8, sof8, eol8, eof8}, {1'b1, held8});
        chk("hold10", {ov10, yuv10, sof10, eol10, eof10}, {1'b1, held10});
      end
      if (ov8 && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", {yuv8, sof8, eol8, eof8}, 64'h0 - 1);
        end else begin
          e = q.pop_front();
          chk("data8", yuv8, e.w8);
          chk("data10", yuv10, e.w10);
          chk("flags8", {sof8, eol8, eof8}, e.fl);
          chk("flags10", {sof10, eol10, eof10}, e.fl);
          chk("valid10", ov10, 1'b1);
          if (lat_on) chk("latency", cyc - e.t, 3);
          last8 = yuv8;
          last10 = yuv10;
          hist.push_back({sof8, eol8, eof8});
        end
      end
      if (in_valid && rdy8) begin
        in_took = 1;
        if (in_sof) begin
          m_mode = mode;
          m_pair = 0;
          m_line = 0;
        end
        e.w8  = yuv(a1[7:0], a1[15:8], a2[7:0], a2[15:8], m_mode);
        e.w10 = yuv(b1[9:2], b1[19:12], b2[9:2], b2[19:12], m_mode);
        e.fl  = {in_sof, m_pair == LP - 1,
                 (m_pair == LP - 1) && (m_line == NL - 1)};
        e.t   = cyc;
        q.push_back(e);
        if (m_pair == LP - 1) begin
          m_pair = 0;
          m_line = (m_line == NL - 1) ? 0 : m_line + 1;
        end else begin
          m_pair++;
        end
      end
      stall_p = ov8 && !out_ready;
      held8   = {yuv8, sof8, eol8, eof8};
      held10  = {yuv10, sof10, eol10, eof10};
    end
  end

  task automatic send(input logic [15:0] x1, x2, input logic [19:0] z1, z2,
                      input bit sof, input logic [1:0] md);
    int n = 0;
    a1 = x1; a2 = x2; b1 = z1; b2 = z2;
    in_sof = sof;
    mode = md;
    in_valid = 1'b1;
    do begin
      @(posedge clk);
      n++;
    end while (!in_took && n < 200);
    if (!in_took) chk("send_timeout", n, 0);
    #1;
    in_valid = 1'b0;
    in_sof = 1'b0;
  endtask

  task automatic send_rnd(input bit sof, input logic [1:0] md);
    send(16'($urandom), 16'($urandom), 20'($urandom), 20'($urandom),
         sof, md);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || ov8) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q.size() != 0 || ov8) chk("drain_timeout", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid8", ov8, 0);
    chk("rst_valid10", ov10, 0);
    chk("rst_data8", yuv8, 0);
    chk("rst_flags8", {sof8, eol8, eof8}, 0);
    chk("rst_flags10", {sof10, eol10, eof10}, 0);
    chk("rst_ready8", rdy8, 1);
    rst = 1'b0;

    send(16'h0000, 16'h0000, 20'h00000, 20'h00000, 1, 2'd0);
    drain();
    chk("t1_zero8", last8, 32'h10801080);

    send(16'hFFFF, 16'hFFFF, 20'hFFFFF, 20'hFFFFF, 0, 2'd0);
    drain();
    chk("t2_ff8", last8, 32'hEB80EB80);
    chk("t2_3ff10", last10, 32'hEB80EB80);

    send(16'h00FF, 16'h0000, 20'h003FF, 20'h00000, 1, 2'd0);
    drain();
    chk("t3_rggb8", last8, 32'h525A52F0);
    chk("t3_rggb10", last10, 32'h525A52F0);
    send(16'h00FF, 16'h0000, 20'h003FF, 20'h00000, 0, 2'd3);
    drain();
    chk("t3_midframe", last8, 32'h525A52F0);
    send(16'h00FF, 16'h0000, 20'h003FF, 20'h00000, 1, 2'd3);
    drain();
    chk("t3_bggr8", last8, 32'h29F0296E);
    chk("t3_bggr10", last10, 32'h29F0296E);

    send(16'hFF00, 16'h0000, 20'hFFC00, 20'h00000, 1, 2'd0);
    drain();
`ifdef RAW2YUV_CHROMA_AVG_EN
    chk("t4_gt8", last8, 32'h905B1051);
`else
    chk("t4_gt8", last8, 32'h90361080);
`endif

    hist.delete();
    for (int i = 0; i < 8; i++) send_rnd(i == 0, 2'($urandom));
    drain();
    chk("t5_count", hist.size(), 8);
    if (hist.size() == 8)
      for (int i = 0; i < 8; i++)
        chk($sformatf("t5_flags%0d", i), hist[i],
            {i == 0, i == 3 || i == 7, i == 7});

    hist.delete();
    for (int i = 0; i < 6; i++) send_rnd(i == 0 || i == 2, 2'($urandom));
    drain();
    chk("t5b_count", hist.size(), 6);
    if (hist.size() == 6)
      for (int i = 0; i < 6; i++)
        chk($sformatf("t5b_flags%0d", i), hist[i],
            {i == 0 || i == 2, i == 5, 1'b0});

    lat_on = 0;
    rdy_mode = 1;
    for (int i = 0; i < 16; i++) begin
      send_rnd(i == 0, 2'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    lat_on = 1;

    rdy_mode = 2;
    send_rnd(1, 2'd1);
    send_rnd(0, 2'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("stall_valid8", ov8, 1);
    chk("stall_ready8", rdy8, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_valid8", ov8, 0);
    chk("rst_mid_valid10", ov10, 0);
    rst = 1'b0;
    rdy_mode = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_flush8", ov8, 0);

    send(16'h00FF, 16'h0000, 20'h003FF, 20'h00000, 0, 2'd3);
    drain();
    chk("rst_mode_rggb", last8, 32'h525A52F0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
